// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I sequencer. It fetches over a req/ready
// handshake, latches the instruction into ir, decodes it, then steps the
// datapath through EXEC, MEM and WB. It owns pc_en and all datapath enables.
// Optional feature: define MC_ILLEGAL_TRAP_EN to make illegal opcodes enter a
// sticky TRAP state. Without the macro, illegal opcodes retire as NOPs.
module multicycle_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] ir,
  output logic            ir_load,
  output logic            alu_src,
  output logic [3:0]      alu_op,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ready,
  output logic            pc_en,
  output logic            trap,
  output logic [2:0]      state
);

  localparam int unsigned SW  = 3;
  localparam int unsigned OPW = 7;

  localparam logic [SW-1:0] S_IDLE   = 3'd0;
  localparam logic [SW-1:0] S_FETCH  = 3'd1;
  localparam logic [SW-1:0] S_DECODE = 3'd2;
  localparam logic [SW-1:0] S_EXEC   = 3'd3;
  localparam logic [SW-1:0] S_MEM    = 3'd4;
  localparam logic [SW-1:0] S_WB     = 3'd5;
  localparam logic [SW-1:0] S_TRAP   = 3'd6;

  localparam logic [OPW-1:0] OP_R     = 7'b0110011;
  localparam logic [OPW-1:0] OP_I     = 7'b0010011;
  localparam logic [OPW-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OPW-1:0] OP_STORE = 7'b0100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  logic [SW-1:0]  state_q, state_d;
  logic [OPW-1:0] opcode;
  logic [2:0]     funct3;
  logic           is_r, is_i, is_ld, is_st, is_legal;

  assign opcode   = ir[6:0];
  assign funct3   = ir[14:12];
  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_ld    = (opcode == OP_LOAD);
  assign is_st    = (opcode == OP_STORE);
  assign is_legal = is_r | is_i | is_ld | is_st;
  assign state    = state_q;

  // State register; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Instruction register captures instr only on the fetch handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ir <= '0;
    else if (ir_load) ir <= instr;
  end

  // ALU control derived from ir; stable for the whole instruction.
  always_comb begin
    alu_src = is_i | is_ld | is_st;
    alu_op  = ALU_ADD;
    if (is_r || is_i) begin
      unique case (funct3)
        3'b000:  alu_op = (is_r && ir[30]) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_op = ALU_SLL;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        3'b101:  alu_op = ir[30] ? ALU_SRA : ALU_SRL;
        3'b110:  alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end
  end

  // Next-state and per-state datapath enables.
  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pc_en      = 1'b0;
    trap       = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        mem_to_reg = is_ld;
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
`ifdef MC_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          pc_en   = 1'b1;
          state_d = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        mem_to_reg = is_ld;
        state_d    = (is_ld || is_st) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_to_reg = is_ld;
        dmem_req   = 1'b1;
        dmem_we    = is_st;
        if (dmem_ready) begin
          if (is_st) begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        mem_to_reg = is_ld;
        reg_write  = 1'b1;
        pc_en      = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
`ifdef MC_ILLEGAL_TRAP_EN
        trap    = 1'b1;
        state_d = S_TRAP;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Inputs change at the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ready;
  logic [31:0] instr, ir;
  logic        ir_load, alu_src;
  logic [3:0]  alu_op;
  logic        mem_to_reg, reg_write, dmem_req, dmem_we, dmem_ready;
  logic        pc_en, trap;
  logic [2:0]  state;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h40208133;
  localparam logic [31:0] I_SRAI  = 32'h4020D193;
  localparam logic [31:0] I_LOAD  = 32'h0000A183;
  localparam logic [31:0] I_STORE = 32'h0020A023;
  localparam logic [31:0] I_ILL   = 32'h0000007F;

  multicycle_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ready(imem_ready), .instr(instr),
    .ir(ir), .ir_load(ir_load), .alu_src(alu_src), .alu_op(alu_op),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // flags = {imem_req, ir_load, mem_to_reg, reg_write, dmem_req, dmem_we, pc_en, trap}
  task automatic chk_cyc(input string tag, input logic [2:0] st, input logic [7:0] flags);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".flags"}, 32'({imem_req, ir_load, mem_to_reg, reg_write,
                              dmem_req, dmem_we, pc_en, trap}), 32'(flags));
  endtask

  task automatic chk_alu(input string tag, input logic [3:0] op, input logic src);
    chk({tag, ".alu_op"}, 32'(alu_op), 32'(op));
    chk({tag, ".alu_src"}, 32'(alu_src), 32'(src));
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; instr = '0;
    @(negedge clk); @(negedge clk); #1;
    chk_cyc("reset", 3'd0, 8'b0000_0000);
    chk("reset.ir", ir, 32'h0);
    chk_alu("reset", 4'b0000, 1'b0);

    // ADD with imem_ready held high; ready is ignored in IDLE
    @(negedge clk); rst_n = 1'b1; imem_ready = 1'b1; instr = I_ADD; #1;
    chk_cyc("add.idle", 3'd0, 8'b0000_0000);
    @(negedge clk); #1; chk_cyc("add.fetch", 3'd1, 8'b1100_0000);
    @(negedge clk); instr = I_SUB; #1;
    chk_cyc("add.decode", 3'd2, 8'b0000_0000);
    chk("add.ir", ir, I_ADD);
    chk_alu("add", 4'b0000, 1'b0);
    @(negedge clk); #1; chk_cyc("add.exec", 3'd3, 8'b0000_0000);
    @(negedge clk); #1; chk_cyc("add.wb", 3'd5, 8'b0001_0010);

    // SUB then SRAI, back-to-back zero-wait fetches
    @(negedge clk); #1; chk_cyc("sub.fetch", 3'd1, 8'b1100_0000);
    @(negedge clk); instr = I_SRAI; #1;
    chk("sub.ir", ir, I_SUB);
    chk_alu("sub", 4'b0001, 1'b0);
    @(negedge clk); #1; chk_cyc("sub.exec", 3'd3, 8'b0000_0000);
    @(negedge clk); #1; chk_cyc("sub.wb", 3'd5, 8'b0001_0010);
    @(negedge clk); #1; chk_cyc("srai.fetch", 3'd1, 8'b1100_0000);
    @(negedge clk); imem_ready = 1'b0; instr = I_LOAD; #1;
    chk("srai.ir", ir, I_SRAI);
    chk_alu("srai", 4'b0111, 1'b1);
    @(negedge clk); #1; chk_cyc("srai.exec", 3'd3, 8'b0000_0000);
    @(negedge clk); #1; chk_cyc("srai.wb", 3'd5, 8'b0001_0010);

    // LOAD: one fetch wait cycle, then dmem_ready delayed 3 cycles
    @(negedge clk); #1;
    chk_cyc("load.fetch_wait", 3'd1, 8'b1000_0000);
    chk("load.ir_hold", ir, I_SRAI);
    @(negedge clk); imem_ready = 1'b1; #1;
    chk_cyc("load.fetch", 3'd1, 8'b1100_0000);
    @(negedge clk); imem_ready = 1'b0; #1;
    chk_cyc("load.decode", 3'd2, 8'b0010_0000);
    chk_alu("load", 4'b0000, 1'b1);
    @(negedge clk); #1; chk_cyc("load.exec", 3'd3, 8'b0010_0000);
    @(negedge clk); #1; chk_cyc("load.mem0", 3'd4, 8'b0010_1000);
    @(negedge clk); #1; chk_cyc("load.mem1", 3'd4, 8'b0010_1000);
    @(negedge clk); #1; chk_cyc("load.mem2", 3'd4, 8'b0010_1000);
    @(negedge clk); dmem_ready = 1'b1; #1;
    chk_cyc("load.mem3", 3'd4, 8'b0010_1000);
    @(negedge clk); dmem_ready = 1'b0; #1;
    chk_cyc("load.wb", 3'd5, 8'b0011_0010);

    // STORE with dmem_ready immediate (held high early; ignored until MEM)
    @(negedge clk); imem_ready = 1'b1; instr = I_STORE; #1;
    chk_cyc("store.fetch", 3'd1, 8'b1100_0000);
    @(negedge clk); #1;
    chk_cyc("store.decode", 3'd2, 8'b0000_0000);
    chk_alu("store", 4'b0000, 1'b1);
    @(negedge clk); dmem_ready = 1'b1; #1;
    chk_cyc("store.exec", 3'd3, 8'b0000_0000);
    @(negedge clk); #1; chk_cyc("store.mem", 3'd4, 8'b0000_1110);

    // Illegal opcode
    @(negedge clk); dmem_ready = 1'b0; instr = I_ILL; #1;
    chk_cyc("ill.fetch", 3'd1, 8'b1100_0000);
    @(negedge clk); imem_ready = 1'b0; #1;
`ifdef MC_ILLEGAL_TRAP_EN
    chk_cyc("ill.decode", 3'd2, 8'b0000_0000);
    @(negedge clk); imem_ready = 1'b1; #1;
    chk_cyc("ill.trap0", 3'd6, 8'b0000_0001);
    @(negedge clk); #1; chk_cyc("ill.trap1", 3'd6, 8'b0000_0001);
`else
    chk_cyc("ill.decode", 3'd2, 8'b0000_0010);
    @(negedge clk); #1; chk_cyc("ill.refetch", 3'd1, 8'b1000_0000);
`endif

    // Reset, then reset again while a LOAD is in MEM with dmem_req high
    @(negedge clk); rst_n = 1'b0; imem_ready = 1'b1; instr = I_LOAD; #1;
    chk_cyc("rst1", 3'd0, 8'b0000_0000);
    chk("rst1.ir", ir, 32'h0);
    @(negedge clk); rst_n = 1'b1; #1; chk_cyc("rst1.idle", 3'd0, 8'b0000_0000);
    @(negedge clk); #1; chk_cyc("rst1.fetch", 3'd1, 8'b1100_0000);
    @(negedge clk); imem_ready = 1'b0; #1;
    @(negedge clk); #1; chk_cyc("rst2.exec", 3'd3, 8'b0010_0000);
    @(negedge clk); #1; chk_cyc("rst2.mem", 3'd4, 8'b0010_1000);
    #2; rst_n = 1'b0; #1;
    chk_cyc("rst2.async", 3'd0, 8'b0000_0000);
    chk("rst2.ir", ir, 32'h0);
    chk_alu("rst2", 4'b0000, 1'b0);
    @(negedge clk); rst_n = 1'b1; imem_ready = 1'b1; #1;
    chk_cyc("rst2.idle", 3'd0, 8'b0000_0000);
    @(negedge clk); #1; chk_cyc("rst2.fetch", 3'd1, 8'b1100_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
